// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: fixed-priority arbitration of pending enabled lines,
// PC redirect to the handler vector, return-PC save/restore and tail-chaining.
module int_sequencer #(
    parameter int          NUM_INT    = 16,
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter int          VEC_STRIDE = 4,
    localparam int         ID_W       = $clog2(NUM_INT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_flag,
    input  logic [NUM_INT-1:0] int_en,
    input  logic               global_en,
    input  logic [15:0]        pc_in,
    input  logic               instr_boundary,
    input  logic               end_routine,
    output logic               redirect,
    output logic [15:0]        redirect_addr,
    output logic [NUM_INT-1:0] ack,
    output logic               busy,
    output logic [ID_W-1:0]    active_id
);

    localparam int STRIDE_SH = $clog2(VEC_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER  = 2'd1,
        S_IN_ISR = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               redirect_q, redirect_d;
    logic [15:0]        redirect_addr_q, redirect_addr_d;
    logic [NUM_INT-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [15:0]        saved_pc_q, saved_pc_d;

    logic [NUM_INT-1:0] pend;
    logic               take;
    logic [ID_W-1:0]    winner;
    logic [15:0]        vec_addr;

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        pend   = int_flag & int_en;
        take   = global_en & (|pend);
        winner = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                winner = ID_W'(i);
            end
        end
        vec_addr = VEC_BASE + (16'(winner) << STRIDE_SH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
            ack_q           <= '0;
            busy_q          <= 1'b0;
            active_id_q     <= '0;
            saved_pc_q      <= '0;
        end else begin
            state_q         <= state_d;
            redirect_q      <= redirect_d;
            redirect_addr_q <= redirect_addr_d;
            ack_q           <= ack_d;
            busy_q          <= busy_d;
            active_id_q     <= active_id_d;
            saved_pc_q      <= saved_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (take && instr_boundary) state_d = S_ENTER;
            S_ENTER:  state_d = S_IN_ISR;
            S_IN_ISR: if (end_routine) state_d = take ? S_ENTER : S_RETURN;
            S_RETURN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so they are
    // valid during the ENTER/RETURN cycle itself. redirect is a one-cycle
    // valid pulse with no ready: the core must take it when it appears.
    always_comb begin
        redirect_d      = 1'b0;
        redirect_addr_d = '0;
        ack_d           = '0;
        busy_d          = (state_d != S_IDLE);
        active_id_d     = active_id_q;
        saved_pc_d      = saved_pc_q;
        case (state_d)
            S_ENTER: begin
                redirect_d      = 1'b1;
                redirect_addr_d = vec_addr;
                ack_d[winner]   = 1'b1;
                active_id_d     = winner;
            end
            S_RETURN: begin
                redirect_d      = 1'b1;
                redirect_addr_d = saved_pc_q;
            end
            default: ;
        endcase
        // Only the first entry saves the PC; chained entries keep the original.
        if (state_q == S_IDLE && state_d == S_ENTER) begin
            saved_pc_d = pc_in;
        end
    end

    assign redirect      = redirect_q;
    assign redirect_addr = redirect_addr_q;
    assign ack           = ack_q;
    assign busy          = busy_q;
    assign active_id     = active_id_q;

endmodule
